// File: rtl/d_ff.sv
// d_ff: positive-edge D flip-flop with complementary outputs.
//
// q is the single stored register. qb is its combinational complement, so
// the two outputs always agree. Reset is synchronous and active-high, and
// it takes priority over d at the same edge. There is no enable; the block
// captures every cycle.
//
// Optional build macro: D_FF_CHECK_EN compiles in the simulation-only
// checker d_ff_checker. The checker watches qb against q, the reset load
// value and the one-cycle d-to-q path. Without the macro no checker logic
// exists and the behaviour is the same.

`ifdef D_FF_CHECK_EN
module d_ff_checker #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input logic             clk,
  input logic             reset,
  input logic [WIDTH-1:0] d,
  input logic [WIDTH-1:0] q,
  input logic [WIDTH-1:0] qb
);

  logic             seen_r;
  logic             prev_reset_r;
  logic [WIDTH-1:0] prev_d_r;

  // remember what the flop sampled at the previous edge (no reset: sim-only observer)
  always_ff @(posedge clk) begin
    seen_r       <= 1'b1;
    prev_reset_r <= reset;
    prev_d_r     <= d;
  end

  // from the second edge on, q must reflect the previous edge's sample and qb must mirror q
  always_ff @(posedge clk) begin
    if (seen_r === 1'b1) begin
      if (qb !== ~q) begin
        $error("d_ff_checker @%0t: qb=%h is not ~q (q=%h)", $time, qb, q);
      end
      if (prev_reset_r === 1'b1) begin
        if (q !== RST_VAL) begin
          $error("d_ff_checker @%0t: q=%h after reset, RST_VAL=%h", $time, q, RST_VAL);
        end
      end else begin
        if (q !== prev_d_r) begin
          $error("d_ff_checker @%0t: q=%h, previous d=%h", $time, q, prev_d_r);
        end
      end
    end
  end

endmodule
`endif

module d_ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             reset
);

  logic [WIDTH-1:0] q_r;

  // storage element: reset wins over d, otherwise capture d on every edge
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= RST_VAL;
    end else begin
      q_r <= d;
    end
  end

  // both outputs come from the one register so they can never disagree
  assign q  = q_r;
  assign qb = ~q_r;

`ifdef D_FF_CHECK_EN
  d_ff_checker #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_checker (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q),
    .qb    (qb)
  );
`else
`endif

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: scoreboard bench for d_ff.
// Two instances: WIDTH=1/RST_VAL=0 and WIDTH=8/RST_VAL=8'hA5.
// The stimulus process drives inputs at the falling edge and pushes the
// value q must show after the next rising edge. Between edges it also
// glitches d and reset, which must have no effect. A monitor pops each
// expectation just after the rising edge and checks q and qb. It checks
// them again late in the cycle to confirm that q held its value.
module tb_d_ff;

  logic       clk_s;
  logic       reset1_s;
  logic       d1_s;
  logic       q1_s;
  logic       qb1_s;
  logic       reset8_s;
  logic [7:0] d8_s;
  logic [7:0] q8_s;
  logic [7:0] qb8_s;

  int unsigned n_cmp;
  int unsigned n_err;
  bit          glitch_en;

  logic       exp1_q[$];
  logic [7:0] exp8_q[$];

  localparam logic [7:0] RST8 = 8'hA5;

  d_ff u_dut1 (
    .q     (q1_s),
    .qb    (qb1_s),
    .d     (d1_s),
    .clk   (clk_s),
    .reset (reset1_s)
  );

  d_ff #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
    .q     (q8_s),
    .qb    (qb8_s),
    .d     (d8_s),
    .clk   (clk_s),
    .reset (reset8_s)
  );

  // 10 ns clock, first rising edge at 5 ns
  initial begin
    clk_s = 1'b0;
    forever #5 clk_s = ~clk_s;
  end

  // reference model: the flop's next q is RST_VAL under reset, otherwise d
  task automatic drive(input logic r1, input logic dv1, input logic r8, input logic [7:0] dv8);
    reset1_s = r1;
    d1_s     = dv1;
    reset8_s = r8;
    d8_s     = dv8;
    exp1_q.push_back(r1 ? 1'b0 : dv1);
    exp8_q.push_back(r8 ? RST8 : dv8);
    @(posedge clk_s);
    #3;
    if (glitch_en) begin
      reset1_s = 1'($urandom_range(0, 1));
      d1_s     = 1'($urandom_range(0, 1));
      reset8_s = 1'($urandom_range(0, 1));
      d8_s     = 8'($urandom_range(0, 255));
    end
    @(negedge clk_s);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %b, required %b", name, $time, act, req);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  // monitor: check right after each edge, then again late in the cycle for hold
  always @(posedge clk_s) begin
    logic       e1;
    logic [7:0] e8;
    #1;
    if (exp1_q.size() > 0 && exp8_q.size() > 0) begin
      e1 = exp1_q.pop_front();
      e8 = exp8_q.pop_front();
      check1("q_w1", q1_s, e1);
      check1("qb_w1", qb1_s, ~e1);
      check8("q_w8", q8_s, e8);
      check8("qb_w8", qb8_s, ~e8);
      #7;
      check1("hold_q_w1", q1_s, e1);
      check1("hold_qb_w1", qb1_s, ~e1);
      check8("hold_q_w8", q8_s, e8);
    end
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    glitch_en = 1'b0;

    // reset with d=1 (q must still load the reset value), then the 8-bit reset with d=3C
    drive(1'b1, 1'b1, 1'b1, 8'h3C);
    // capture pattern; the 8-bit instance leaves reset with d=3C
    drive(1'b0, 1'b1, 1'b0, 8'h3C);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    glitch_en = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'hFF);
    drive(1'b0, 1'b1, 1'b0, 8'h81);
    drive(1'b0, 1'b0, 1'b0, 8'h7E);
    drive(1'b0, 1'b0, 1'b0, 8'h5A);
    drive(1'b0, 1'b1, 1'b0, 8'hC3);
    // reset priority over d=1, then release with d=1
    drive(1'b1, 1'b1, 1'b1, 8'hFF);
    drive(1'b0, 1'b1, 1'b0, 8'h3C);
    drive(1'b1, 1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'hA5);

    // randomized phase
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
            8'($urandom_range(0, 255)));
    end

    // let the monitor drain the last expectation
    glitch_en = 1'b0;
    repeat (3) @(posedge clk_s);
    #2;
    n_cmp++;
    if (exp1_q.size() != 0 || exp8_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", exp1_q.size(), exp8_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
